// File: rtl/store_narrow_unit.sv
// Narrows a register value to byte/half/word and writes it out one little-endian byte per beat.
// Latency N+1 cycles for N bytes (1 when rejected). mem_ready low stalls WRITE with the byte held stable.
module store_narrow_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              done,
   output logic              err_align,
   output logic              trunc_ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W-1:0] base_r;
   logic [31:0]       data_r;
   logic [1:0]        idx_r;
   logic [1:0]        last_r;
   logic              err_r;
   logic              ovf_r;

   logic              accept;
   logic              reject;
   logic              ovf_calc;
   logic [1:0]        last_calc;
   logic              last_beat;

   // req_ready is combinational from state, so the accept condition mirrors it exactly
   assign accept    = req_valid && (state == S_IDLE) && !reset;
   assign last_beat = (idx_r == last_r);

   always_comb begin
      reject    = 1'b0;
      ovf_calc  = 1'b0;
      last_calc = 2'd0;
      case (req_size)
         SZ_BYTE: begin
            ovf_calc  = (req_data[31:8] != {24{req_data[7]}});
            last_calc = 2'd0;
         end
         SZ_HALF: begin
            reject    = req_addr[0];
            ovf_calc  = (req_data[31:16] != {16{req_data[15]}});
            last_calc = 2'd1;
         end
         SZ_WORD: begin
            reject    = (req_addr[1:0] != 2'b00);
            last_calc = 2'd3;
         end
         default: begin
            reject    = 1'b1;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = reject ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            if (mem_ready && last_beat) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Request capture and byte index; flags are frozen at acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_r <= '0;
         data_r <= '0;
         idx_r  <= 2'd0;
         last_r <= 2'd0;
         err_r  <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         base_r <= req_addr;
         data_r <= req_data;
         idx_r  <= 2'd0;
         last_r <= last_calc;
         err_r  <= reject;
         ovf_r  <= reject ? 1'b0 : ovf_calc;
      end else if ((state == S_WRITE) && mem_ready && !last_beat) begin
         idx_r <= idx_r + 2'd1;
      end
   end

   // Output logic
   always_comb begin
      req_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      done      = 1'b0;
      err_align = 1'b0;
      trunc_ovf = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = !reset;
         end
         S_WRITE: begin
            mem_we   = 1'b1;
            mem_addr = base_r + {{(ADDR_W-2){1'b0}}, idx_r};
            case (idx_r)
               2'd0:    mem_wdata = data_r[7:0];
               2'd1:    mem_wdata = data_r[15:8];
               2'd2:    mem_wdata = data_r[23:16];
               default: mem_wdata = data_r[31:24];
            endcase
         end
         S_DONE: begin
            done      = 1'b1;
            err_align = err_r;
            trunc_ovf = ovf_r;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed vector table, hand-written corner sequences, random requests vs a reference model.
module tb_store_narrow_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        done;
   logic        err_align;
   logic        trunc_ovf;

   int total = 0;
   int bad   = 0;

   store_narrow_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .done      (done),
      .err_align (err_align),
      .trunc_ovf (trunc_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        err;
      logic        ovf;
      int          n;
      int          cyc;
      logic [31:0] bytes_le;
   } vec_t;

   // Results captured by do_store
   logic [31:0] got_addr [8];
   logic [7:0]  got_dat  [8];
   int          got_n;
   logic        got_err;
   logic        got_ovf;
   int          got_cyc;
   int          got_stalls;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // mode 0: mem_ready always high; 1: random; 2: low for 3 cycles while the 2nd byte is presented
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input int mode);
      logic        prev_stall;
      logic [31:0] prev_addr;
      logic [7:0]  prev_dat;
      got_n = 0; got_err = 1'bx; got_ovf = 1'bx; got_cyc = -1; got_stalls = 0;
      prev_stall = 1'b0; prev_addr = '0; prev_dat = '0;
      chk("ready_before_req", req_ready, 1);
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
      for (int c = 1; c <= 200; c++) begin
         case (mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 99) < 65);
            default: mem_ready = !(got_n == 1 && got_stalls < 3);
         endcase
         if (prev_stall) begin
            chk("stall_hold_we", mem_we, 1);
            chk("stall_hold_addr", mem_addr, prev_addr);
            chk("stall_hold_data", mem_wdata, prev_dat);
         end
         if (mem_we) begin
            if (mem_ready) begin
               if (got_n < 8) begin
                  got_addr[got_n] = mem_addr;
                  got_dat[got_n]  = mem_wdata;
               end
               got_n++;
            end else begin
               got_stalls++;
            end
            prev_stall = !mem_ready;
            prev_addr  = mem_addr;
            prev_dat   = mem_wdata;
         end else begin
            prev_stall = 1'b0;
         end
         if (done) begin
            got_err = err_align;
            got_ovf = trunc_ovf;
            got_cyc = c;
            break;
         end
         @(posedge clk); @(negedge clk);
      end
      if (got_cyc < 0) begin
         chk("done_timeout", 0, 1);
      end else begin
         @(posedge clk); @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("ready_after_done", req_ready, 1);
      end
   endtask

   task automatic check_result(input string nm, input logic [31:0] a, input logic err, input logic ovf,
                               input int n, input logic [31:0] bytes_le, input int cyc);
      chk({nm, "_err"}, got_err, err);
      chk({nm, "_ovf"}, got_ovf, ovf);
      chk({nm, "_nbytes"}, got_n, n);
      chk({nm, "_cycle"}, got_cyc, cyc);
      for (int i = 0; i < n && i < got_n && i < 8; i++) begin
         chk({nm, "_addr"}, got_addr[i], a + 32'(i));
         chk({nm, "_byte"}, got_dat[i], 8'(bytes_le >> (8 * i)));
      end
   endtask

   // Reference model from the rules in value terms: legality by address modulo size, overflow by signed range
   task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        output logic err, output logic ovf, output int n);
      int v;
      v   = $signed(d);
      err = (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
      ovf = 1'b0;
      n   = 0;
      if (!err) begin
         n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
         if (s == 2'd0) ovf = (v < -128) || (v > 127);
         if (s == 2'd1) ovf = (v < -32768) || (v > 32767);
      end
   endtask

   vec_t vecs [12];

   logic        s_we   [8];
   logic [31:0] s_addr [8];
   logic [7:0]  s_dat  [8];
   logic        s_done [8];
   logic        s_rdy  [8];

   initial begin
      vecs[0]  = '{32'h0000_0100, 32'hFFFF_FF85, 2'd0, 1'b0, 1'b0, 1, 2, 32'h0000_0085};
      vecs[1]  = '{32'h0000_0202, 32'h0001_8000, 2'd1, 1'b0, 1'b1, 2, 3, 32'h0000_8000};
      vecs[2]  = '{32'h0000_0400, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 4, 5, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h0000_0201, 32'h0000_1234, 2'd1, 1'b1, 1'b0, 0, 1, 32'h0};
      vecs[4]  = '{32'h0000_0402, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0, 0, 1, 32'h0};
      vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 2'd3, 1'b1, 1'b0, 0, 1, 32'h0};
      vecs[6]  = '{32'h0000_0007, 32'h0000_007F, 2'd0, 1'b0, 1'b0, 1, 2, 32'h0000_007F};
      vecs[7]  = '{32'h0000_0008, 32'h0000_0080, 2'd0, 1'b0, 1'b1, 1, 2, 32'h0000_0080};
      vecs[8]  = '{32'hFFFF_FFFC, 32'h1122_3344, 2'd2, 1'b0, 1'b0, 4, 5, 32'h1122_3344};
      vecs[9]  = '{32'hFFFF_FFFE, 32'hFFFF_8000, 2'd1, 1'b0, 1'b0, 2, 3, 32'h0000_8000};
      vecs[10] = '{32'h0000_0003, 32'hFFFF_FF7F, 2'd0, 1'b0, 1'b1, 1, 2, 32'h0000_007F};
      vecs[11] = '{32'h0000_0006, 32'hFFFF_7FFF, 2'd1, 1'b0, 1'b1, 2, 3, 32'h0000_7FFF};

      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_done", done, 0);
      chk("rst_err_align", err_align, 0);
      chk("rst_trunc_ovf", trunc_ovf, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b0;
      #1;
      chk("idle_req_ready", req_ready, 1);
      @(negedge clk);

      // Directed vector table, mem_ready tied high
      for (int i = 0; i < 12; i++) begin
         do_store(vecs[i].addr, vecs[i].data, vecs[i].size, 0);
         check_result($sformatf("vec%0d", i), vecs[i].addr, vecs[i].err, vecs[i].ovf,
                      vecs[i].n, vecs[i].bytes_le, vecs[i].cyc);
      end

      // Word store with a 3-cycle stall on the second byte
      do_store(32'h0000_0400, 32'hDEAD_BEEF, 2'd2, 2);
      chk("stall_count", got_stalls, 3);
      check_result("word_stall", 32'h0000_0400, 1'b0, 1'b0, 4, 32'hDEAD_BEEF, 8);

      // Reset in the middle of a word store, after the 2nd byte is taken
      mem_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h0000_0400; req_data = 32'hCAFE_F00D; req_size = 2'd2;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_b0", mem_wdata, 8'h0D);
      @(posedge clk); @(negedge clk);
      chk("rstmid_b1_addr", mem_addr, 32'h0000_0401);
      chk("rstmid_b1", mem_wdata, 8'hF0);
      @(posedge clk); @(negedge clk);
      chk("rstmid_b2_we", mem_we, 1);
      reset = 1'b1;
      #1;
      chk("rstmid_we_drop", mem_we, 0);
      chk("rstmid_ready_low", req_ready, 0);
      chk("rstmid_no_done", done, 0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); @(negedge clk);
         chk("rstmid_hold_we", mem_we, 0);
         chk("rstmid_hold_done", done, 0);
      end
      reset = 1'b0;
      #1;
      chk("rstmid_ready_after", req_ready, 1);
      chk("rstmid_done_after", done, 0);
      @(negedge clk);
      do_store(32'h0000_0300, 32'h0000_0042, 2'd0, 0);
      check_result("post_reset", 32'h0000_0300, 1'b0, 1'b0, 1, 32'h0000_0042, 2);

      // Back-to-back byte stores with req_valid held high
      mem_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h0000_0500; req_data = 32'h0000_0011; req_size = 2'd0;
      @(posedge clk); @(negedge clk);
      for (int c = 1; c <= 7; c++) begin
         s_we[c]   = mem_we;
         s_addr[c] = mem_addr;
         s_dat[c]  = mem_wdata;
         s_done[c] = done;
         s_rdy[c]  = req_ready;
         if (c == 1) begin
            req_addr = 32'h0000_0600; req_data = 32'h0000_0022;
         end
         if (c == 4) req_valid = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      chk("b2b_c1_we", s_we[1], 1);
      chk("b2b_c1_addr", s_addr[1], 32'h0000_0500);
      chk("b2b_c1_dat", s_dat[1], 8'h11);
      chk("b2b_c1_rdy", s_rdy[1], 0);
      chk("b2b_c2_done", s_done[2], 1);
      chk("b2b_c2_rdy", s_rdy[2], 0);
      chk("b2b_c2_we", s_we[2], 0);
      chk("b2b_c3_rdy", s_rdy[3], 1);
      chk("b2b_c3_we", s_we[3], 0);
      chk("b2b_c4_we", s_we[4], 1);
      chk("b2b_c4_addr", s_addr[4], 32'h0000_0600);
      chk("b2b_c4_dat", s_dat[4], 8'h22);
      chk("b2b_c5_done", s_done[5], 1);
      chk("b2b_c6_rdy", s_rdy[6], 1);
      chk("b2b_c7_we", s_we[7], 0);
      chk("b2b_c7_done", s_done[7], 0);

      // Random requests with random memory stalls against the reference model
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         logic [31:0] d;
         logic [1:0]  s;
         logic        e_err;
         logic        e_ovf;
         int          e_n;
         s = 2'($urandom_range(0, 3));
         a = $urandom;
         if (k % 10 == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) begin
            if (s == 2'd1) a[0] = 1'b0;
            if (s == 2'd2) a[1:0] = 2'b00;
         end
         case ($urandom_range(0, 2))
            0:       d = $urandom;
            1:       d = 32'($signed(8'($urandom)));
            default: d = 32'($signed(16'($urandom)));
         endcase
         model(a, d, s, e_err, e_ovf, e_n);
         do_store(a, d, s, 1);
         check_result($sformatf("rnd%0d", k), a, e_err, e_ovf, e_n, d,
                      e_err ? 1 : (e_n + 1 + got_stalls));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Write-side counterpart of the immediate/load sign-extension path in the multicycle MIPS datapath.
- Takes a 32-bit register value plus an access size (sb/sh/sw) and narrows it to the requested width.
- Serialises the narrowed value onto an 8-bit little-endian memory write port, one byte per accepted beat.
- Flags misaligned/illegal requests, and truncation overflow: the stored value does not sign-extend back to the original 32-bit value.

Parameters:
ADDR_W, 32, width of request and memory byte addresses

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  unit idle and able to accept a request
req_addr  input  ADDR_W  byte address of the store
req_data  input  32  register value to store
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
mem_we  output  1  byte write valid this cycle
mem_ready  input  1  memory accepts the byte presented this cycle
mem_addr  output  ADDR_W  byte address of current write
mem_wdata  output  8  byte being written
done  output  1  one-cycle pulse: request finished (written or rejected)
err_align  output  1  valid with done: request rejected, no bytes written
trunc_ovf  output  1  valid with done: narrowed value does not sign-extend to req_data

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE; byte index 0.
  - mem_we, done, err_align, trunc_ovf = 0; mem_addr, mem_wdata = 0.
  - req_ready = 0 while reset is asserted.
  - Reset mid-operation aborts immediately: no further writes and no done pulse.
- States: IDLE, WRITE, DONE.
- IDLE:
  - req_ready = 1.
  - A request is accepted on the rising edge where req_valid && req_ready; base address, data, size and index 0 are latched.
  - Reject conditions: size 11; size 01 with addr[0] = 1; size 10 with addr[1:0] != 0.
  - If the request is rejected: go to DONE with err_align = 1 and trunc_ovf = 0. No write is issued.
  - Otherwise: go to WRITE, with last index = 0 (byte), 1 (half) or 3 (word).
- trunc_ovf is computed at acceptance and held until DONE:
  - byte: data[31:8] != {24{data[7]}}
  - half: data[31:16] != {16{data[15]}}
  - word: always 0
- WRITE:
  - mem_we = 1, mem_addr = base + index, mem_wdata = data[8*index+7 : 8*index].
  - Little-endian byte order.
  - Outputs stay stable while mem_ready = 0; stalls are unbounded.
  - On mem_ready = 1: if index == last, go to DONE; otherwise increment index.
  - req_ready = 0 throughout.
- DONE:
  - done = 1 for exactly one cycle, with err_align and trunc_ovf valid; mem_we = 0.
  - Next state is always IDLE. A new request cannot be accepted in the DONE cycle.
  - Back-to-back requests have a minimum spacing of N+2 cycles, where N is the number of bytes written.
- Latency with mem_ready tied high:
  - Accept edge at cycle 0; writes in cycles 1..N; done in cycle N+1.
  - Rejected requests: done in cycle 1.
- Address arithmetic is modulo 2^ADDR_W; wrap at the top of memory is permitted for aligned accesses.
- Inputs are ignored outside the IDLE accept edge.

Test Plan:
- Byte store: addr 0x100, data 0xFFFFFF85, size 00, mem_ready = 1 -> one write (0x100, 0x85); done next cycle with err_align = 0, trunc_ovf = 0.
- Halfword with overflow: addr 0x202, data 0x00018000, size 01 -> writes (0x202, 0x00) then (0x203, 0x80); done with trunc_ovf = 1.
- Word with stalls: addr 0x400, data 0xDEADBEEF, mem_ready low for 3 cycles on the 2nd byte -> writes EF, BE, AD, DE to 0x400..0x403; outputs hold during the stall; done with flags 0.
- Misaligned/illegal:
  - half at 0x201 -> done at cycle 1, err_align = 1, mem_we never asserted.
  - word at 0x402 -> same response.
  - size 11 -> same response.
- Reset during WRITE: assert reset after the 2nd byte of a word store -> mem_we drops immediately and no done pulse. After reset release, req_ready = 1 and a new byte store completes normally.
- Back-to-back: req_valid held high with two byte stores -> the second is accepted only in IDLE after the first done; total 3 cycles per store; no byte lost or duplicated.
